// File: rtl/vx_sfu_sched_if.sv
// Dispatch-side request, per-unit request/response and merged commit signals of the SFU scheduler.
// master drives the scheduler inputs (dispatch + units + commit sink), slave is the scheduler.
interface vx_sfu_sched_if #(
  parameter int NUM_UNITS = 6,
  parameter int DATAW     = 64,
  parameter int UNIT_BITS = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
);
  logic                       req_valid;
  logic [UNIT_BITS-1:0]       req_unit;
  logic                       req_ready;
  logic [NUM_UNITS-1:0]       unit_req_valid;
  logic [NUM_UNITS-1:0]       unit_req_ready;
  logic [NUM_UNITS-1:0]       unit_rsp_valid;
  logic [NUM_UNITS*DATAW-1:0] unit_rsp_data;
  logic [NUM_UNITS-1:0]       unit_rsp_ready;
  logic                       rsp_valid;
  logic [DATAW-1:0]           rsp_data;
  logic                       rsp_ready;

  modport master (
    output req_valid, req_unit, unit_req_ready, unit_rsp_valid, unit_rsp_data, rsp_ready,
    input  req_ready, unit_req_valid, unit_rsp_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_unit, unit_req_ready, unit_rsp_valid, unit_rsp_data, rsp_ready,
    output req_ready, unit_req_valid, unit_rsp_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/vx_sfu_sched.sv
// Routes SFU requests to sub-units under per-unit credit limits; merges responses round-robin.
// Requests: zero latency. Responses: one registered stage, 1/cycle; unit_rsp_ready held low while the output stalls.
module vx_sfu_sched #(
  parameter int NUM_UNITS   = 6,
  parameter int DATAW       = 64,
  parameter int MAX_PENDING = 4,
  parameter int UNIT_BITS   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  vx_sfu_sched_if.slave bus,
  output logic          idle,
  output logic [1:0]    err
);
  localparam int CNTW = $clog2(MAX_PENDING + 1);

  logic [CNTW-1:0]      count [NUM_UNITS];
  logic [NUM_UNITS-1:0] full, ureq_vld, ursp_rdy, req_fire, rsp_fire, uflow;
  logic                 req_rdy, idx_ok, load_en, gnt_vld, rsp_vld_q;
  logic [UNIT_BITS-1:0] ptr, gnt_idx, cand;
  logic [DATAW-1:0]     gnt_dat, rsp_dat_q;

  function automatic int wrap_idx(int v);
    return (v >= NUM_UNITS) ? v - NUM_UNITS : v;
  endfunction

  // An out-of-range req_unit matches no unit, so it stalls with req_ready low.
  always_comb begin
    full     = '0;
    ureq_vld = '0;
    req_rdy  = 1'b0;
    idx_ok   = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      full[u] = (count[u] == CNTW'(MAX_PENDING));
      if (bus.req_unit == UNIT_BITS'(u)) begin
        idx_ok      = 1'b1;
        ureq_vld[u] = bus.req_valid & ~full[u];
        req_rdy     = bus.unit_req_ready[u] & ~full[u];
      end
    end
  end

  assign load_en = ~rsp_vld_q | bus.rsp_ready;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = ptr;
    cand     = ptr;
    gnt_dat  = '0;
    ursp_rdy = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = UNIT_BITS'(wrap_idx(int'(ptr) + i));
      if (!gnt_vld && bus.unit_rsp_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (gnt_idx == UNIT_BITS'(u)) begin
        gnt_dat     = bus.unit_rsp_data[u*DATAW +: DATAW];
        ursp_rdy[u] = gnt_vld & load_en;
      end
    end
  end

  assign req_fire = ureq_vld & bus.unit_req_ready;
  assign rsp_fire = bus.unit_rsp_valid & ursp_rdy;

  // A response fire on an empty counter is still consumed; it only raises the sticky flag.
  always_comb begin
    uflow = '0;
    idle  = ~rsp_vld_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      uflow[u] = rsp_fire[u] & ~req_fire[u] & (count[u] == '0);
      if (count[u] != '0) idle = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_q <= 1'b0;
      ptr       <= '0;
      err       <= '0;
      for (int u = 0; u < NUM_UNITS; u++) count[u] <= '0;
    end else begin
      if (load_en) begin
        rsp_vld_q <= gnt_vld;
        if (gnt_vld)
          ptr <= (gnt_idx == UNIT_BITS'(NUM_UNITS - 1)) ? '0 : gnt_idx + UNIT_BITS'(1);
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (req_fire[u] && !rsp_fire[u])
          count[u] <= count[u] + CNTW'(1);
        else if (rsp_fire[u] && !req_fire[u] && count[u] != '0)
          count[u] <= count[u] - CNTW'(1);
      end
      err <= err | {|uflow, bus.req_valid & ~idx_ok};
    end
  end

  // Payload register is intentionally unreset; rsp_valid qualifies it.
  always_ff @(posedge clk) begin
    if (load_en && gnt_vld) rsp_dat_q <= gnt_dat;
  end

  assign bus.req_ready      = req_rdy;
  assign bus.unit_req_valid = ureq_vld;
  assign bus.unit_rsp_ready = ursp_rdy;
  assign bus.rsp_valid      = rsp_vld_q;
  assign bus.rsp_data       = rsp_dat_q;
endmodule
